// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter_pkg
// Description : Shared definitions for the CPU/DMA bus arbiter: bus word
//               width, arbiter state encoding and nominal DMA transfer shape.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package dma_bus_arbiter_pkg;

  localparam int WORD_SIZE       = `WORD_SIZE;
  localparam int WORDS_PER_BURST = 4;
  localparam int BURSTS          = 3;
  // Cycles of bus ownership for one nominal DMA transfer.
  localparam int NOMINAL_GRANT   = WORDS_PER_BURST * BURSTS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    GRANT   = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_arb_timer.sv
`default_nettype none
// ============================================================================
// Module      : dma_arb_timer
// Description : Loadable down-counter that saturates at zero. Used for the
//               post-release CPU ownership gap and the grant watchdog.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - load i_load_val (wins over i_en)
//               i_load_val[W]   - value to load
//               i_en            - decrement by one when nonzero
//               o_zero          - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module dma_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_arbiter
// Description : Arbitrates the shared memory bus between the CPU and the DMA
//               engine. A DMA request is granted only after the CPU's
//               in-flight access retires; the CPU is stalled for the whole
//               grant window and gets the bus back for at least GAP_CYCLES
//               after each release, with a one-cycle dma_done pulse.
// Ports       : CLK, reset_n   - clock, async active-low reset
//               BR              - DMA bus request (level)
//               cpu_mem_busy    - CPU memory access in flight
//               BG              - bus grant to DMA (registered)
//               cpu_stall       - block new CPU memory accesses (registered)
//               dma_done        - one-cycle pulse when the bus returns
//               grant_cnt[CNT_W]- completed grants since reset (wraps)
//               wd_err          - sticky watchdog error
// Options     : DMA_ARB_WATCHDOG_EN - when defined, a grant held for
//               MAX_GRANT cycles is forcibly released and wd_err is set;
//               otherwise wd_err is tied low and grants are unbounded.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_GRANT  = NOMINAL_GRANT + 4,
  parameter int CNT_W      = WORD_SIZE
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             BR,
  input  logic             cpu_mem_busy,
  output logic             BG,
  output logic             cpu_stall,
  output logic             dma_done,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             wd_err
);

  localparam int GAP_W = 4;

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic             r_bg;
  logic             r_stall;
  logic             r_done;
  logic [CNT_W-1:0] r_grant_cnt;
  logic             w_gap_zero;
  logic             w_wd_zero;
  logic             w_wd_fire;

  // Gap countdown: loaded on the single RELEASE cycle so GAP lasts exactly
  // GAP_CYCLES cycles before returning to IDLE.
  dma_arb_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (CLK),
    .rst_n      (reset_n),
    .i_load     (r_state == RELEASE),
    .i_load_val (GAP_W'(GAP_CYCLES - 1)),
    .i_en       (r_state == GAP),
    .o_zero     (w_gap_zero)
  );

`ifdef DMA_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_GRANT + 1);

  logic r_wd_err;

  // Loaded on GRANT entry with MAX_GRANT-1 so that the zero flag is seen on
  // the MAX_GRANT-th grant cycle.
  dma_arb_timer #(.W(WD_W)) u_wd_timer (
    .clk        (CLK),
    .rst_n      (reset_n),
    .i_load     ((w_next == GRANT) && (r_state != GRANT)),
    .i_load_val (WD_W'(MAX_GRANT - 1)),
    .i_en       (r_state == GRANT),
    .o_zero     (w_wd_zero)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_err <= 1'b0;
    end else if (w_wd_fire) begin
      r_wd_err <= 1'b1;
    end
  end

  assign wd_err = r_wd_err;
`else
  assign w_wd_zero = 1'b0;
  assign wd_err    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wd_fire = 1'b0;
    case (r_state)
      IDLE: begin
        // A CPU access starting in the same cycle wins the tie: drain first.
        if (BR) begin
          w_next = cpu_mem_busy ? DRAIN : GRANT;
        end
      end
      DRAIN: begin
        if (!BR) begin
          w_next = IDLE;
        end else if (!cpu_mem_busy) begin
          w_next = GRANT;
        end
      end
      GRANT: begin
        // cpu_mem_busy is deliberately ignored here: the grant is held.
        if (!BR) begin
          w_next = RELEASE;
        end else if (w_wd_zero) begin
          w_next    = RELEASE;
          w_wd_fire = 1'b1;
        end
      end
      RELEASE: begin
        w_next = GAP;
      end
      GAP: begin
        if (w_gap_zero) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe without any combinational decode on the pins.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_bg        <= 1'b0;
      r_stall     <= 1'b0;
      r_done      <= 1'b0;
      r_grant_cnt <= '0;
    end else begin
      r_bg    <= (w_next == GRANT);
      r_stall <= (w_next == DRAIN) || (w_next == GRANT) || (w_next == RELEASE);
      r_done  <= (w_next == RELEASE);
      if (w_next == RELEASE) begin
        r_grant_cnt <= r_grant_cnt + 1'b1;
      end
    end
  end

  assign BG        = r_bg;
  assign cpu_stall = r_stall;
  assign dma_done  = r_done;
  assign grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire
